// File: rtl/lcd_pkg.sv
// Shared timing constants, counter widths and power-state encoding
// for the 480x272 parallel-RGB LCD raster generator.
package lcd_pkg;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 9;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BP     = 2;
    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BP     = 2;

    localparam int LCD_H_TOTAL =
        LCD_H_ACTIVE + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;
    localparam int LCD_V_TOTAL =
        LCD_V_ACTIVE + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

    localparam int LCD_H_SYNC_START = LCD_H_ACTIVE + LCD_H_FP;
    localparam int LCD_H_SYNC_END   = LCD_H_SYNC_START + LCD_H_SYNC - 1;
    localparam int LCD_V_SYNC_START = LCD_V_ACTIVE + LCD_V_FP;
    localparam int LCD_V_SYNC_END   = LCD_V_SYNC_START + LCD_V_SYNC - 1;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAIT = 2'd1,
        S_ON   = 2'd2
    } pwr_state_t;

endpackage

// File: rtl/lcd_timing_gen_delay_line.sv
// Parameterized-depth shift register with a parameterized reset value,
// used to align panel pins with the renderer pipeline.
module lcd_delay_line #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_lcd,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            sr <= {DEPTH{RST_VAL}};
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: pixel coordinates, active flags, panel
// sync/DE aligned to the renderer pipeline, frame tick and DISP power-up.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = LCD_H_ACTIVE,
    parameter int H_FP       = LCD_H_FP,
    parameter int H_SYNC     = LCD_H_SYNC,
    parameter int H_BP       = LCD_H_BP,
    parameter int V_ACTIVE   = LCD_V_ACTIVE,
    parameter int V_FP       = LCD_V_FP,
    parameter int V_SYNC     = LCD_V_SYNC,
    parameter int V_BP       = LCD_V_BP,
    parameter int PIPE       = 2,
    parameter int PWR_FRAMES = 4
) (
    input  logic              clk_lcd,
    input  logic              rst,
    output logic [HCNT_W-1:0] hcount_reg,
    output logic [VCNT_W-1:0] Vcount_reg,
    output logic              flagh,
    output logic              flagv,
    output logic              rgb_en,
    output logic              lcd_hsync_n,
    output logic              lcd_vsync_n,
    output logic              lcd_de,
    output logic              lcd_disp,
    output logic              frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_END = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_SS  = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] H_SE  =
        HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [VCNT_W-1:0] V_END = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_SS  = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] V_SE  =
        VCNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [2:0] PWR_LAST = 3'(PWR_FRAMES - 1);

    logic              h_wrap;
    logic [HCNT_W-1:0] h_nxt;
    logic [VCNT_W-1:0] v_nxt;
    logic              hs_raw_n;
    logic              vs_raw_n;
    logic              de_raw;
    logic              de_dly;
    pwr_state_t        state;
    logic [2:0]        tick_cnt;

    always_comb begin
        h_wrap = (hcount_reg == H_END);
        h_nxt  = h_wrap ? '0 : hcount_reg + 1'b1;
        v_nxt  = Vcount_reg;
        if (h_wrap) begin
            v_nxt = (Vcount_reg == V_END) ? '0 : Vcount_reg + 1'b1;
        end
    end

    // Flags and raw syncs look at the next count so they line up
    // with the counters in the same cycle.
    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            hcount_reg <= '0;
            Vcount_reg <= '0;
            flagh      <= 1'b0;
            flagv      <= 1'b0;
            hs_raw_n   <= 1'b1;
            vs_raw_n   <= 1'b1;
            rgb_en     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hcount_reg <= h_nxt;
            Vcount_reg <= v_nxt;
            flagh      <= (h_nxt < H_ACT);
            flagv      <= (v_nxt < V_ACT);
            hs_raw_n   <= !((h_nxt >= H_SS) && (h_nxt <= H_SE));
            vs_raw_n   <= !((v_nxt >= V_SS) && (v_nxt <= V_SE));
            rgb_en     <= de_raw;
            frame_tick <= (h_nxt == '0) && (v_nxt == V_ACT);
        end
    end

    assign de_raw = flagh & flagv;

    lcd_delay_line #(.DEPTH(PIPE), .RST_VAL(1'b1)) u_hs_dly (
        .clk_lcd (clk_lcd),
        .rst     (rst),
        .d       (hs_raw_n),
        .q       (lcd_hsync_n)
    );

    lcd_delay_line #(.DEPTH(PIPE), .RST_VAL(1'b1)) u_vs_dly (
        .clk_lcd (clk_lcd),
        .rst     (rst),
        .d       (vs_raw_n),
        .q       (lcd_vsync_n)
    );

    lcd_delay_line #(.DEPTH(PIPE), .RST_VAL(1'b0)) u_de_dly (
        .clk_lcd (clk_lcd),
        .rst     (rst),
        .d       (de_raw),
        .q       (de_dly)
    );

    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            state    <= S_OFF;
            tick_cnt <= '0;
            lcd_disp <= 1'b0;
        end else begin
            unique case (state)
                S_OFF: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (frame_tick) begin
                        if (tick_cnt == PWR_LAST) begin
                            state    <= S_ON;
                            lcd_disp <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_ON: begin
                    lcd_disp <= 1'b1;
                end
                default: begin
                    state    <= S_OFF;
                    lcd_disp <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_de = de_dly & (state == S_ON);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen using a shrunken raster
// (17 clocks x 13 lines) so several frames fit in a short run.
module tb_lcd_timing_gen;

    localparam int HA = 10, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 6,  VFP = 2, VS = 3, VBP = 2;
    localparam int HT = 17;
    localparam int VT = 13;
    localparam int FR = 221;
    // Ticks land at edges 102, 323, 544, 765; DISP is up one edge later.
    localparam int ON_EDGE = 766;

    logic       clk_lcd = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcount_reg;
    logic [8:0] Vcount_reg;
    logic       flagh, flagv, rgb_en;
    logic       lcd_hsync_n, lcd_vsync_n, lcd_de, lcd_disp, frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int e = 0;
    int fh_cnt, hs_cnt, vs_cnt, tk_cnt;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIPE(2), .PWR_FRAMES(4)
    ) dut (
        .clk_lcd     (clk_lcd),
        .rst         (rst),
        .hcount_reg  (hcount_reg),
        .Vcount_reg  (Vcount_reg),
        .flagh       (flagh),
        .flagv       (flagv),
        .rgb_en      (rgb_en),
        .lcd_hsync_n (lcd_hsync_n),
        .lcd_vsync_n (lcd_vsync_n),
        .lcd_de      (lcd_de),
        .lcd_disp    (lcd_disp),
        .frame_tick  (frame_tick)
    );

    always #5 clk_lcd = ~clk_lcd;

    function automatic int hx(int k);
        return (k <= 0) ? 0 : (k % FR) % HT;
    endfunction

    function automatic int vy(int k);
        return (k <= 0) ? 0 : (k % FR) / HT;
    endfunction

    function automatic logic fh(int k);
        return (k >= 1) && (hx(k) < HA);
    endfunction

    function automatic logic fv(int k);
        return (k >= 1) && (vy(k) < VA);
    endfunction

    function automatic logic hs_n(int k);
        return !((k >= 1) && hx(k) >= 12 && hx(k) <= 14);
    endfunction

    function automatic logic vs_n(int k);
        return !((k >= 1) && vy(k) >= 8 && vy(k) <= 10);
    endfunction

    function automatic logic de(int k);
        return fh(k) & fv(k);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s e=%0d observed=%0d expected=%0d",
                   tag, e, obs, exp);
        end
    endtask

    task automatic check_all();
        logic on;
        on = (e >= ON_EDGE);
        check("hcount", int'(hcount_reg), hx(e));
        check("vcount", int'(Vcount_reg), vy(e));
        check("flagh", int'(flagh), int'(fh(e)));
        check("flagv", int'(flagv), int'(fv(e)));
        check("rgb_en", int'(rgb_en), int'(de(e - 1)));
        check("hsync_n", int'(lcd_hsync_n), int'(hs_n(e - 2)));
        check("vsync_n", int'(lcd_vsync_n), int'(vs_n(e - 2)));
        check("lcd_de", int'(lcd_de), int'(on & de(e - 2)));
        check("lcd_disp", int'(lcd_disp), int'(on));
        check("frame_tick", int'(frame_tick),
              int'(e >= 1 && hx(e) == 0 && vy(e) == VA));
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk_lcd);
            #1;
            e++;
            check_all();
            if (e >= 17 && e <= 33 && flagh) fh_cnt++;
            if (e >= 19 && e <= 35 && !lcd_hsync_n) hs_cnt++;
            if (e >= 2 && e <= 222 && !lcd_vsync_n) vs_cnt++;
            if (frame_tick) tk_cnt++;
        end
    endtask

    initial begin
        fh_cnt = 0; hs_cnt = 0; vs_cnt = 0; tk_cnt = 0;
        rst = 1'b1;
        repeat (5) @(posedge clk_lcd);
        #1;
        e = 0;
        check_all();
        rst = 1'b0;

        @(posedge clk_lcd);
        #1;
        e = 1;
        check("first_h", int'(hcount_reg), 1);
        check("first_v", int'(Vcount_reg), 0);
        check("first_flags", int'({flagh, flagv}), 3);
        check_all();

        run(971);
        check("mid_h", int'(hcount_reg), 3);
        check("mid_v", int'(Vcount_reg), 5);
        check("mid_disp", int'(lcd_disp), 1);
        check("flagh_width", fh_cnt, 10);
        check("hsync_width", hs_cnt, 3);
        check("vsync_width", vs_cnt, 51);
        check("ticks_p1", tk_cnt, 4);

        rst = 1'b1;
        @(posedge clk_lcd);
        #1;
        e = 0;
        check("rst_h", int'(hcount_reg), 0);
        check("rst_v", int'(Vcount_reg), 0);
        check("rst_disp", int'(lcd_disp), 0);
        check("rst_syncs", int'({lcd_hsync_n, lcd_vsync_n}), 3);
        check_all();
        rst = 1'b0;

        fh_cnt = 0; hs_cnt = 0; vs_cnt = 0; tk_cnt = 0;
        run(1000);
        check("flagh_width2", fh_cnt, 10);
        check("vsync_width2", vs_cnt, 51);
        check("ticks_p2", tk_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
